// File: rtl/ether_pkg.sv
// Shared types and constants for the ether_feeder dibit transmitter.
package ether_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_WAIT,
    S_DATA,
    S_PAD,
    S_DONE,
    S_HOLD
  } state_e;

  localparam int unsigned MIN_PAYLOAD_DIBITS = 184;
  localparam int unsigned DIBITS_PER_BYTE    = 4;

endpackage

// File: rtl/byte_fifo.sv
// Synchronous first-word-fall-through FIFO; rd_data_o always shows the head entry.
module byte_fifo #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             do_wr;
  logic             do_rd;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign do_wr   = wr_en_i & ~full_o;
  assign do_rd   = rd_en_i & ~empty_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_rd) rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/ether_feeder.sv
// Buffers payload bytes and streams each frame as LSB-first dibits with preamble/complete pulses.
// Define ETHER_FEEDER_PAD_EN to zero-pad short frames up to MIN_PAYLOAD_DIBITS.
module ether_feeder #(
  parameter int unsigned FIFO_DEPTH = 256,
  parameter int unsigned HDR_WAIT   = 88,
  parameter int unsigned HOLDOFF    = 48
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       s_valid,
  input  logic       s_last,
  input  logic [7:0] s_data,
  output logic       s_ready,
  output logic       axiov,
  output logic [1:0] axiod,
  output logic       preamble_signal,
  output logic       data_complete,
  output logic       busy,
  output logic       trunc_err
);
  import ether_pkg::*;

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned FW = AW + 1;
  localparam logic [FW-1:0] FB_LAST    = FW'(FIFO_DEPTH - 1);
  localparam logic [FW-1:0] F_ONE      = 1;
  localparam logic [15:0]   WAIT_INIT  = 16'(HDR_WAIT - 2);
  localparam logic [15:0]   HOLD_INIT  = 16'(HOLDOFF - 1);
  localparam logic [1:0]    LAST_PHASE = 2'(DIBITS_PER_BYTE - 1);
`ifdef ETHER_FEEDER_PAD_EN
  localparam logic [11:0]   MIN_DIB    = 12'(MIN_PAYLOAD_DIBITS);
`endif

  logic          rdy_q;
  logic          discard_q;
  logic          trunc_q;
  logic [FW-1:0] fb_cnt_q;
  logic [FW-1:0] frames_q;

  logic          fifo_full;
  logic          fifo_empty;
  logic [8:0]    fifo_dout;
  logic          accept;
  logic          wr_en;
  logic          force_last;
  logic          wr_last;
  logic          frame_in;
  logic          enter_pre;
  logic          pop;
  logic          tmr_zero;

  state_e        state_q;
  logic [15:0]   tmr_q;
  logic [5:0]    sh_q;
  logic [1:0]    phase_q;
  logic          last_q;
  logic [11:0]   dcnt_q;
  logic          axiov_q;
  logic [1:0]    axiod_q;
  logic          pre_q;
  logic          dc_q;

  // While discarding a truncated tail, bytes are swallowed regardless of FIFO space.
  assign s_ready    = rdy_q & (discard_q | ~fifo_full);
  assign accept     = s_valid & s_ready;
  assign wr_en      = accept & ~discard_q;
  assign force_last = ~s_last & (fb_cnt_q == FB_LAST);
  assign wr_last    = s_last | force_last;
  assign frame_in   = wr_en & wr_last;

  assign tmr_zero  = (tmr_q == '0);
  assign enter_pre = (frames_q != '0) & ~fifo_empty &
                     ((state_q == S_IDLE) | ((state_q == S_HOLD) & tmr_zero));
  assign pop       = ((state_q == S_WAIT) & tmr_zero) |
                     ((state_q == S_DATA) & (phase_q == LAST_PHASE) & ~last_q);

  byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (9)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (wr_en),
    .wr_data_i ({wr_last, s_data}),
    .rd_en_i   (pop),
    .rd_data_o (fifo_dout),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q     <= 1'b0;
      discard_q <= 1'b0;
      trunc_q   <= 1'b0;
      fb_cnt_q  <= '0;
      frames_q  <= '0;
    end else begin
      rdy_q <= 1'b1;
      if (wr_en) begin
        fb_cnt_q <= wr_last ? '0 : fb_cnt_q + F_ONE;
        if (force_last) begin
          discard_q <= 1'b1;
          trunc_q   <= 1'b1;
        end
      end
      if (accept && discard_q && s_last) discard_q <= 1'b0;
      case ({frame_in, enter_pre})
        2'b10:   frames_q <= frames_q + F_ONE;
        2'b01:   frames_q <= frames_q - F_ONE;
        default: frames_q <= frames_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      tmr_q   <= '0;
      sh_q    <= '0;
      phase_q <= '0;
      last_q  <= 1'b0;
      dcnt_q  <= '0;
      axiov_q <= 1'b0;
      axiod_q <= '0;
      pre_q   <= 1'b0;
      dc_q    <= 1'b0;
    end else begin
      pre_q <= 1'b0;
      dc_q  <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (enter_pre) begin
            state_q <= S_PRE;
            pre_q   <= 1'b1;
          end
        end
        S_PRE: begin
          state_q <= S_WAIT;
          tmr_q   <= WAIT_INIT;
        end
        S_WAIT: begin
          if (tmr_zero) begin
            state_q <= S_DATA;
            axiov_q <= 1'b1;
            axiod_q <= fifo_dout[1:0];
            sh_q    <= fifo_dout[7:2];
            last_q  <= fifo_dout[8];
            phase_q <= '0;
            dcnt_q  <= 12'd1;
          end else begin
            tmr_q <= tmr_q - 16'd1;
          end
        end
        S_DATA: begin
          if (phase_q != LAST_PHASE) begin
            axiod_q <= sh_q[1:0];
            sh_q    <= {2'b00, sh_q[5:2]};
            phase_q <= phase_q + 2'd1;
            dcnt_q  <= dcnt_q + 12'd1;
          end else if (!last_q) begin
            // Head byte is already visible on the FWFT output, so the next byte follows without a gap.
            axiod_q <= fifo_dout[1:0];
            sh_q    <= fifo_dout[7:2];
            last_q  <= fifo_dout[8];
            phase_q <= '0;
            dcnt_q  <= dcnt_q + 12'd1;
          end else
`ifdef ETHER_FEEDER_PAD_EN
          if (dcnt_q < MIN_DIB) begin
            state_q <= S_PAD;
            axiod_q <= 2'b00;
            dcnt_q  <= dcnt_q + 12'd1;
          end else
`endif
          begin
            state_q <= S_DONE;
            axiov_q <= 1'b0;
            axiod_q <= 2'b00;
            dc_q    <= 1'b1;
          end
        end
`ifdef ETHER_FEEDER_PAD_EN
        S_PAD: begin
          if (dcnt_q >= MIN_DIB) begin
            state_q <= S_DONE;
            axiov_q <= 1'b0;
            axiod_q <= 2'b00;
            dc_q    <= 1'b1;
          end else begin
            dcnt_q <= dcnt_q + 12'd1;
          end
        end
`endif
        S_DONE: begin
          state_q <= S_HOLD;
          tmr_q   <= HOLD_INIT;
        end
        S_HOLD: begin
          // A pending frame leaves holdoff straight into PRE, skipping the IDLE cycle.
          if (tmr_zero) begin
            if (enter_pre) begin
              state_q <= S_PRE;
              pre_q   <= 1'b1;
            end else begin
              state_q <= S_IDLE;
            end
          end else begin
            tmr_q <= tmr_q - 16'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign axiov           = axiov_q;
  assign axiod           = axiod_q;
  assign preamble_signal = pre_q;
  assign data_complete   = dc_q;
  assign busy            = (state_q != S_IDLE);
  assign trunc_err       = trunc_q;

endmodule

// File: tb/tb_ether_feeder.sv
// Directed bench for ether_feeder: framing latency, dibit order, padding, back-to-back, truncation, reset.
module tb_ether_feeder;

`ifdef ETHER_FEEDER_PAD_EN
  localparam int N10 = 184;
  localparam int N1  = 184;
`else
  localparam int N10 = 40;
  localparam int N1  = 4;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       s_valid = 1'b0;
  logic       s_last = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       s_ready;
  logic       axiov;
  logic [1:0] axiod;
  logic       preamble_signal;
  logic       data_complete;
  logic       busy;
  logic       trunc_err;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int idle_bad = 0;
  int pre_t[$];
  int dc_t[$];
  int dib_t[$];
  logic [1:0] dib_v[$];

  always #5 clk = ~clk;

  ether_feeder #(
    .FIFO_DEPTH (256),
    .HDR_WAIT   (88),
    .HOLDOFF    (48)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .s_valid         (s_valid),
    .s_last          (s_last),
    .s_data          (s_data),
    .s_ready         (s_ready),
    .axiov           (axiov),
    .axiod           (axiod),
    .preamble_signal (preamble_signal),
    .data_complete   (data_complete),
    .busy            (busy),
    .trunc_err       (trunc_err)
  );

  always @(negedge clk) begin
    if (preamble_signal === 1'b1) pre_t.push_back(cyc);
    if (data_complete === 1'b1) dc_t.push_back(cyc);
    if (axiov === 1'b1) begin
      dib_t.push_back(cyc);
      dib_v.push_back(axiod);
    end else if (axiod !== 2'b00) begin
      idle_bad++;
    end
    cyc++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] d, input logic last, output int stalls);
    int t = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    while (s_ready !== 1'b1 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 5000) chk("push_ready_timeout", {31'b0, s_ready}, 32'd1);
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
    stalls  = t;
  endtask

  task automatic push_frame(input logic [7:0] base, input int n, output int stalls);
    int s;
    stalls = 0;
    for (int i = 0; i < n; i++) begin
      push(base + 8'(i), (i == n - 1), s);
      stalls += s;
    end
  endtask

  task automatic wait_dc(input int n, input string tag);
    int t = 0;
    while (dc_t.size() < n && t < 20000) begin
      @(negedge clk);
      #1;
      t++;
    end
    chk(tag, 32'(dc_t.size() >= n), 32'd1);
  endtask

  task automatic check_frame(input string tag, input int first, input logic [7:0] base,
                             input int nbytes, input int total);
    int errs = 0;
    logic [7:0] b;
    logic [1:0] e;
    for (int k = 0; k < total; k++) begin
      if (k < nbytes * 4) begin
        b = base + 8'(k / 4);
        e = 2'(b >> (2 * (k % 4)));
      end else begin
        e = 2'b00;
      end
      if (first + k >= dib_v.size()) errs++;
      else if (dib_v[first + k] !== e) errs++;
    end
    chk({tag, "_data"}, errs, 0);
    chk({tag, "_contig"}, dib_t[first + total - 1] - dib_t[first], total - 1);
  endtask

  initial begin
    int pb, db, cb, st, late, t;

    repeat (2) @(negedge clk);
    chk("rst_s_ready", {31'b0, s_ready}, 0);
    chk("rst_axiov", {31'b0, axiov}, 0);
    chk("rst_axiod", {30'b0, axiod}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_trunc", {31'b0, trunc_err}, 0);
    chk("rst_dc", {31'b0, data_complete}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_s_ready", {31'b0, s_ready}, 1);
    chk("rel_busy", {31'b0, busy}, 0);

    // 10-byte frame 0x00..0x09
    pb = pre_t.size(); db = dib_v.size(); cb = dc_t.size();
    push_frame(8'h00, 10, st);
    wait_dc(cb + 1, "t1_dc_seen");
    chk("t1_pre_cnt", pre_t.size() - pb, 1);
    chk("t1_first_lat", dib_t[db] - pre_t[pb], 88);
    chk("t1_dibits", dib_v.size() - db, N10);
    check_frame("t1", db, 8'h00, 10, N10);
    chk("t1_dc_gap", dc_t[cb] - dib_t[db + N10 - 1], 1);

    // Single byte 0xB4 -> 00,01,11,10
    pb = pre_t.size(); db = dib_v.size(); cb = dc_t.size();
    push(8'hB4, 1'b1, st);
    wait_dc(cb + 1, "t2_dc_seen");
    chk("t2_d0", {30'b0, dib_v[db]}, 0);
    chk("t2_d1", {30'b0, dib_v[db + 1]}, 1);
    chk("t2_d2", {30'b0, dib_v[db + 2]}, 3);
    chk("t2_d3", {30'b0, dib_v[db + 3]}, 2);
    chk("t2_dibits", dib_v.size() - db, N1);
    check_frame("t2", db, 8'hB4, 1, N1);

    // Two 60-byte frames back to back
    pb = pre_t.size(); db = dib_v.size(); cb = dc_t.size();
    push_frame(8'h00, 60, st);
    push_frame(8'hA0, 60, st);
    wait_dc(cb + 2, "t3_dc_seen");
    chk("t3_pre_gap", pre_t[pb + 1] - dc_t[cb], 49);
    chk("t3_dibits", dib_v.size() - db, 480);
    check_frame("t3a", db, 8'h00, 60, 240);
    check_frame("t3b", db + 240, 8'hA0, 60, 240);
    chk("t3b_lat", dib_t[db + 240] - pre_t[pb + 1], 88);
    chk("t3a_dc_gap", dc_t[cb] - dib_t[db + 239], 1);

    // 300-byte frame truncated at 256, then a normal 10-byte frame
    pb = pre_t.size(); db = dib_v.size(); cb = dc_t.size();
    late = 0;
    for (int i = 0; i < 300; i++) begin
      push(8'(i), (i == 299), st);
      if (i >= 256) late += st;
    end
    chk("t4_discard_ready", late, 0);
    chk("t4_trunc_set", {31'b0, trunc_err}, 1);
    push_frame(8'h40, 10, st);
    wait_dc(cb + 2, "t4_dc_seen");
    chk("t4_pre_cnt", pre_t.size() - pb, 2);
    chk("t4_dibits", dib_v.size() - db, 1024 + N10);
    check_frame("t4a", db, 8'h00, 256, 1024);
    check_frame("t4b", db + 1024, 8'h40, 10, N10);
    chk("t4_trunc_sticky", {31'b0, trunc_err}, 1);

    // Reset at dibit 100 of a 60-byte frame
    pb = pre_t.size(); db = dib_v.size(); cb = dc_t.size();
    push_frame(8'h00, 60, st);
    t = 0;
    while (dib_v.size() - db < 100 && t < 2000) begin
      @(negedge clk);
      #1;
      t++;
    end
    chk("t5_at_100", dib_v.size() - db, 100);
    rst_n = 1'b0;
    #1;
    chk("t5_axiov", {31'b0, axiov}, 0);
    chk("t5_axiod", {30'b0, axiod}, 0);
    chk("t5_busy", {31'b0, busy}, 0);
    chk("t5_s_ready", {31'b0, s_ready}, 0);
    chk("t5_trunc", {31'b0, trunc_err}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (300) @(negedge clk);
    #1;
    chk("t5_no_dc", dc_t.size() - cb, 0);
    chk("t5_no_dibits", dib_v.size() - db, 100);
    chk("t5_no_pre", pre_t.size() - pb, 1);
    chk("t5_idle", {31'b0, busy}, 0);

    // Fresh frame after reset sees an empty FIFO
    pb = pre_t.size(); db = dib_v.size(); cb = dc_t.size();
    push_frame(8'h20, 10, st);
    wait_dc(cb + 1, "t6_dc_seen");
    chk("t6_pre_cnt", pre_t.size() - pb, 1);
    chk("t6_first_lat", dib_t[db] - pre_t[pb], 88);
    chk("t6_dibits", dib_v.size() - db, N10);
    check_frame("t6", db, 8'h20, 10, N10);

    chk("idle_axiod_zero", idle_bad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
